// File: rtl/dram_spram_pkg.sv
// Shared constants and types for the dram_spram data RAM.
package dram_spram_pkg;

  localparam int unsigned ADDR_WIDTH = 13;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BYTE_SIZE  = 8;
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / BYTE_SIZE;
  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [BE_WIDTH-1:0]   be_t;
  typedef logic [BYTE_SIZE-1:0]  byte_t;

endpackage

// File: rtl/dram_spram_if.sv
// Single-port RAM access bus: address, write strobe/lanes/data, registered read data.
interface dram_spram_if;
  import dram_spram_pkg::*;

  addr_t addr;
  data_t wr_data;
  logic  wr_en;
  be_t   wr_byte_en;
  data_t rd_data;

  modport master (output addr, output wr_data, output wr_en, output wr_byte_en, input rd_data);
  modport slave  (input addr, input wr_data, input wr_en, input wr_byte_en, output rd_data);

endinterface

// File: rtl/dram_byte_lane.sv
// One byte-wide, DEPTH-deep storage lane with its own write enable; read path is combinational.
module dram_byte_lane
  import dram_spram_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  addr_t addr,
  input  byte_t wr_byte,
  output byte_t rd_byte_c
);

  // Storage is intentionally never reset or initialized.
  byte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_byte;
    end
  end

  assign rd_byte_c = mem[addr];

endmodule

// File: rtl/dram_spram.sv
// 8K x 32 single-port data RAM, per-byte writes, one-cycle registered read in normal-write mode.
module dram_spram
  import dram_spram_pkg::*;
(
  input  logic         clk,
  input  logic         tb_rst,
  dram_spram_if.slave  bus
);

  be_t   lane_we;
  data_t rd_word_c;
  data_t rd_q;

  // Writes are suppressed while reset is held.
  assign lane_we = {BE_WIDTH{bus.wr_en & ~tb_rst}} & bus.wr_byte_en;

  for (genvar i = 0; i < BE_WIDTH; i++) begin : g_lane
    dram_byte_lane u_lane (
      .clk       (clk),
      .we        (lane_we[i]),
      .addr      (bus.addr),
      .wr_byte   (bus.wr_data[i*BYTE_SIZE +: BYTE_SIZE]),
      .rd_byte_c (rd_word_c[i*BYTE_SIZE +: BYTE_SIZE])
    );
  end

  // Output register only loads on read cycles; write cycles hold the last read word.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      rd_q <= '0;
    end else if (!bus.wr_en) begin
      rd_q <= rd_word_c;
    end
  end

  assign bus.rd_data = rd_q;

endmodule

// File: tb/tb_dram_spram.sv
// Scoreboard bench for dram_spram: reset, full sweep, byte lanes, write hold, mid-run reset, boundaries.
module tb_dram_spram;
  import dram_spram_pkg::*;

  logic clk;
  logic tb_rst;
  int   vectors;
  int   miscompares;
  data_t exp_q[$];

  dram_spram_if bus ();

  dram_spram dut (
    .clk    (clk),
    .tb_rst (tb_rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic data_t sweep_val(int n);
    return 32'hFFFF_FFFF - 32'(n - 1);
  endfunction

  task automatic drive_write(input addr_t a, input data_t d, input be_t be);
    bus.addr       = a;
    bus.wr_data    = d;
    bus.wr_byte_en = be;
    bus.wr_en      = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_read(input addr_t a, input data_t expv);
    bus.addr       = a;
    bus.wr_en      = 1'b0;
    bus.wr_byte_en = $urandom_range(15, 0);
    bus.wr_data    = $urandom;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    data_t got;
    tb_rst         = 1'b1;
    bus.addr       = '0;
    bus.wr_data    = '0;
    bus.wr_en      = 1'b0;
    bus.wr_byte_en = '0;
    #1;
    for (int t = 0; t < 20; t++) begin
      bus.addr  = addr_t'($urandom);
      bus.wr_en = 1'(t & 1);
      got = bus.rd_data;
      vectors++;
      if (got !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_hold t=%0d rd_data=%h expected=%h", t, got, 32'h0);
      end
      #10;
    end
    @(posedge clk);
    #1;
    bus.wr_en      = 1'b1;
    bus.wr_byte_en = '0;
    tb_rst         = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      got = bus.rd_data;
      vectors++;
      if (got !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_release_noread c=%0d rd_data=%h expected=%h", c, got, 32'h0);
      end
    end
  endtask

  task automatic test_sweep();
    data_t got;
    data_t expv;
    for (int n = 1; n <= int'(DEPTH); n++) begin
      drive_write(addr_t'(n), sweep_val(n), 4'hF);
    end
    for (int n = 1; n <= int'(DEPTH); n++) begin
      drive_read(addr_t'(n), sweep_val(n));
      got  = bus.rd_data;
      expv = exp_q.pop_front();
      vectors++;
      if (got !== expv) begin
        miscompares++;
        $display("FAIL sweep_read addr=%h rd_data=%h expected=%h", addr_t'(n), got, expv);
      end
    end
  endtask

  task automatic test_byte_enable();
    data_t got;
    data_t expv;
    drive_write(13'd5, 32'h1122_3344, 4'hF);
    drive_write(13'd5, 32'hAABB_CCDD, 4'b0101);
    drive_read(13'd5, 32'h11BB_33DD);
    got  = bus.rd_data;
    expv = exp_q.pop_front();
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL byte_enable rd_data=%h expected=%h", got, expv);
    end
    drive_write(13'd5, 32'hFFFF_FFFF, 4'h0);
    drive_read(13'd5, 32'h11BB_33DD);
    got  = bus.rd_data;
    expv = exp_q.pop_front();
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL byte_enable_none rd_data=%h expected=%h", got, expv);
    end
  endtask

  task automatic test_write_hold();
    data_t got;
    data_t expv;
    drive_read(13'd5, 32'h11BB_33DD);
    got  = bus.rd_data;
    expv = exp_q.pop_front();
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL hold_pre_read rd_data=%h expected=%h", got, expv);
    end
    drive_write(13'd6, 32'hDEAD_BEEF, 4'hF);
    got = bus.rd_data;
    vectors++;
    if (got !== 32'h11BB_33DD) begin
      miscompares++;
      $display("FAIL hold_during_write rd_data=%h expected=%h", got, 32'h11BB_33DD);
    end
    drive_read(13'd6, 32'hDEAD_BEEF);
    got  = bus.rd_data;
    expv = exp_q.pop_front();
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL hold_read_new rd_data=%h expected=%h", got, expv);
    end
  endtask

  task automatic test_mid_reset();
    data_t got;
    data_t expv;
    drive_read(13'd7, sweep_val(7));
    got  = bus.rd_data;
    expv = exp_q.pop_front();
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL midrst_pre rd_data=%h expected=%h", got, expv);
    end
    #2;
    tb_rst = 1'b1;
    #1;
    got = bus.rd_data;
    vectors++;
    if (got !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_async rd_data=%h expected=%h", got, 32'h0);
    end
    // A write attempted under reset must not land.
    drive_write(13'd2, 32'h1234_5678, 4'hF);
    got = bus.rd_data;
    vectors++;
    if (got !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_held rd_data=%h expected=%h", got, 32'h0);
    end
    tb_rst         = 1'b0;
    bus.wr_byte_en = '0;
    @(posedge clk);
    #1;
    got = bus.rd_data;
    vectors++;
    if (got !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_release rd_data=%h expected=%h", got, 32'h0);
    end
    drive_read(13'd2, 32'hFFFF_FFFE);
    got  = bus.rd_data;
    expv = exp_q.pop_front();
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL midrst_retained rd_data=%h expected=%h", got, expv);
    end
  endtask

  task automatic test_boundary();
    data_t got;
    data_t expv;
    drive_read(13'h0000, 32'hFFFF_E000);
    got  = bus.rd_data;
    expv = exp_q.pop_front();
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL bound_lo rd_data=%h expected=%h", got, expv);
    end
    drive_read(13'h1FFF, 32'hFFFF_E001);
    got  = bus.rd_data;
    expv = exp_q.pop_front();
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL bound_hi rd_data=%h expected=%h", got, expv);
    end
    drive_write(13'h1FFF, 32'h0BAD_F00D, 4'hF);
    drive_read(13'h0000, 32'hFFFF_E000);
    got  = bus.rd_data;
    expv = exp_q.pop_front();
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL bound_alias_lo rd_data=%h expected=%h", got, expv);
    end
    drive_read(13'h1FFF, 32'h0BAD_F00D);
    got  = bus.rd_data;
    expv = exp_q.pop_front();
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL bound_alias_hi rd_data=%h expected=%h", got, expv);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_sweep();
    test_mid_reset();
    test_byte_enable();
    test_write_hold();
    test_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
